// File: rtl/inst_fetch_resp_pkg.sv
// Shared types for the instruction-fetch responder: FSM encoding and the one-entry fetch buffer.
package inst_fetch_resp_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_e;

  // Address-tagged instruction entry; err entries always carry zero data.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        valid;
  } ibuf_t;

endpackage

// File: rtl/inst_fetch_resp_if.sv
// Fetch-side (PC register / IF-ID) and bus-side (instruction memory) handshakes.
interface ifetch_if;
  logic        ce_i;
  logic [31:0] pc_i;
  logic        flush;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_err_o;
  logic        stallreq_o;

  modport master (output ce_i, pc_i, flush, input inst_o, inst_valid_o, inst_err_o, stallreq_o);
  modport slave  (input ce_i, pc_i, flush, output inst_o, inst_valid_o, inst_err_o, stallreq_o);
endinterface

interface imem_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_rdata_i, mem_err_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_rdata_i, mem_err_i);
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: one-entry tagged buffer in front of a req/ack instruction bus,
// with stall request on miss and error reporting for misaligned pc, bus error and timeout.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  ifetch_if.slave    fe,
  imem_if.master     mem
);

  fetch_state_e state;
  ibuf_t        ibuf;
  logic         drop;
  logic [7:0]   cnt;
  logic [31:0]  addr_q;

  logic aligned, hit, discard, expire;

  assign aligned = (fe.pc_i[1:0] == 2'b00);
  assign hit     = ibuf.valid && (ibuf.addr == fe.pc_i);
  // A flush landing on the completing cycle also kills the fill.
  assign discard = drop || fe.flush;
  assign expire  = (cnt == 8'(TIMEOUT - 1));

  assign mem.mem_req_o  = (state == FETCH_REQ);
  assign mem.mem_addr_o = addr_q;

  always_comb begin
    fe.inst_o       = ZERO_WORD;
    fe.inst_valid_o = 1'b0;
    fe.inst_err_o   = 1'b0;
    fe.stallreq_o   = 1'b0;
    if (rst || !fe.ce_i) begin
      fe.inst_o = ZERO_WORD;
    end else if (!aligned) begin
      fe.inst_valid_o = 1'b1;
      fe.inst_err_o   = 1'b1;
    end else if (hit) begin
      fe.inst_o       = ibuf.err ? ZERO_WORD : ibuf.data;
      fe.inst_valid_o = 1'b1;
      fe.inst_err_o   = ibuf.err;
    end else begin
      fe.stallreq_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH_IDLE;
      ibuf   <= '0;
      drop   <= 1'b0;
      cnt    <= 8'd0;
      addr_q <= ZERO_WORD;
    end else if (state == FETCH_IDLE) begin
      if (fe.flush) begin
        ibuf.valid <= 1'b0;
      end else if (fe.ce_i && aligned && !hit) begin
        state  <= FETCH_REQ;
        addr_q <= fe.pc_i;
        cnt    <= 8'd0;
      end
    end else begin
      if (mem.mem_ack_i) begin
        ibuf.addr  <= addr_q;
        ibuf.data  <= mem.mem_err_i ? ZERO_WORD : mem.mem_rdata_i;
        ibuf.err   <= mem.mem_err_i;
        ibuf.valid <= !discard;
        drop       <= 1'b0;
        state      <= FETCH_IDLE;
      end else if (expire) begin
        ibuf.addr  <= addr_q;
        ibuf.data  <= ZERO_WORD;
        ibuf.err   <= 1'b1;
        ibuf.valid <= !discard;
        drop       <= 1'b0;
        state      <= FETCH_IDLE;
      end else begin
        cnt <= cnt + 8'd1;
        if (fe.flush) drop <= 1'b1;
      end
    end
  end

endmodule
